// File: rtl/ps2_key_ctrl_if.sv
// Bundles the PS/2 receive-FIFO side and the key-event side of ps2_key_ctrl.
// master = the key controller, slave = its environment (receive FIFO + consumer).
interface ps2_key_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    input  kbd_data, kbd_ready, kbd_overflow, evt_ready,
    output kbd_nextdata_n, evt_code, evt_ext, evt_break, evt_valid
  );

  modport slave (
    output kbd_data, kbd_ready, kbd_overflow, evt_ready,
    input  kbd_nextdata_n, evt_code, evt_ext, evt_break, evt_valid
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-byte sequencer: fetch, E0/F0 prefix parse, modifier tracking, event FIFO.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic makes of keys already held.
module ps2_key_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               clr,
  ps2_key_ctrl_if.master     bus,
  output logic [3:0]         mods,
  output logic [1:0]         err_flags,
  input  logic               err_clr
);

  typedef enum logic [1:0] {FETCH, POP, WAIT} fetch_e;
  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXTBRK} parse_e;

  fetch_e      fetch_q;
  logic        nextdata_n_q;
  logic        byte_vld_q;
  logic [7:0]  byte_q;

  parse_e      parse_q;
  logic        emit_q;
  logic [7:0]  emit_code_q;
  logic        emit_ext_q;
  logic        emit_brk_q;

  logic        is_e0;
  logic        is_f0;
  logic        is_junk;

  // Byte fetch: one pop pulse, then two idle cycles to cover receive-FIFO pop latency.
  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_q      <= FETCH;
      nextdata_n_q <= 1'b1;
      byte_vld_q   <= 1'b0;
      byte_q       <= 8'h00;
    end else begin
      nextdata_n_q <= 1'b1;
      byte_vld_q   <= 1'b0;
      case (fetch_q)
        FETCH: begin
          if (bus.kbd_ready) begin
            byte_q       <= bus.kbd_data;
            byte_vld_q   <= 1'b1;
            nextdata_n_q <= 1'b0;
            fetch_q      <= POP;
          end
        end
        POP:     fetch_q <= WAIT;
        WAIT:    fetch_q <= FETCH;
        default: fetch_q <= FETCH;
      endcase
    end
  end

  assign bus.kbd_nextdata_n = nextdata_n_q;

  assign is_e0 = (byte_q == 8'hE0);
  assign is_f0 = (byte_q == 8'hF0);

  always_comb begin
    is_junk = 1'b0;
    case (byte_q)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_junk = 1'b1;
      default:                                  is_junk = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      parse_q     <= P_IDLE;
      emit_q      <= 1'b0;
      emit_code_q <= 8'h00;
      emit_ext_q  <= 1'b0;
      emit_brk_q  <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (byte_vld_q) begin
        case (parse_q)
          P_IDLE: begin
            if (is_e0)      parse_q <= P_EXT;
            else if (is_f0) parse_q <= P_BRK;
            else if (!is_junk) begin
              emit_q      <= 1'b1;
              emit_code_q <= byte_q;
              emit_ext_q  <= 1'b0;
              emit_brk_q  <= 1'b0;
            end
          end
          P_EXT: begin
            if (is_f0)      parse_q <= P_EXTBRK;
            else if (is_e0) parse_q <= P_EXT;
            else begin
              emit_q      <= 1'b1;
              emit_code_q <= byte_q;
              emit_ext_q  <= 1'b1;
              emit_brk_q  <= 1'b0;
              parse_q     <= P_IDLE;
            end
          end
          P_BRK: begin
            if (is_e0)      parse_q <= P_EXTBRK;
            else if (is_f0) parse_q <= P_BRK;
            else begin
              emit_q      <= 1'b1;
              emit_code_q <= byte_q;
              emit_ext_q  <= 1'b0;
              emit_brk_q  <= 1'b1;
              parse_q     <= P_IDLE;
            end
          end
          default: begin
            if (!(is_e0 || is_f0)) begin
              emit_q      <= 1'b1;
              emit_code_q <= byte_q;
              emit_ext_q  <= 1'b1;
              emit_brk_q  <= 1'b1;
              parse_q     <= P_IDLE;
            end
          end
        endcase
      end
    end
  end

  logic push_en;

`ifdef PS2_REPEAT_FILTER_EN
  // Held-key map: 128 codes in each of the plain and E0 planes; codes >= 80 pass unfiltered.
  logic [255:0] held_q;
  logic [7:0]   held_idx;
  logic         filt_ok;

  assign held_idx = {emit_ext_q, emit_code_q[6:0]};
  assign filt_ok  = !emit_code_q[7];
  assign push_en  = emit_q && !(filt_ok && !emit_brk_q && held_q[held_idx]);

  always_ff @(posedge clk) begin
    if (clr) begin
      held_q <= '0;
    end else if (emit_q && filt_ok) begin
      held_q[held_idx] <= !emit_brk_q;
    end
  end
`else
  assign push_en = emit_q;
`endif

  logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q, caps_held_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (emit_q) begin
      case ({emit_ext_q, emit_code_q})
        9'h012: lshift_q <= !emit_brk_q;
        9'h059: rshift_q <= !emit_brk_q;
        9'h014: lctrl_q  <= !emit_brk_q;
        9'h114: rctrl_q  <= !emit_brk_q;
        9'h011: lalt_q   <= !emit_brk_q;
        9'h111: ralt_q   <= !emit_brk_q;
        9'h058: begin
          // Held bit keeps typematic repeats from toggling caps lock again.
          if (!emit_brk_q && !caps_held_q) caps_q <= !caps_q;
          caps_held_q <= !emit_brk_q;
        end
        default: ;
      endcase
    end
  end

  assign mods = {caps_q, lalt_q | ralt_q, lctrl_q | rctrl_q, lshift_q | rshift_q};

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, pop, wr_en, drop;
  logic [9:0]    head;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign pop   = (cnt_q != '0) && bus.evt_ready;
  assign wr_en = push_en && (!full || pop);
  assign drop  = push_en && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {emit_code_q, emit_ext_q, emit_brk_q};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.evt_valid = (cnt_q != '0);
  assign bus.evt_code  = bus.evt_valid ? head[9:2] : 8'h00;
  assign bus.evt_ext   = bus.evt_valid & head[1];
  assign bus.evt_break = bus.evt_valid & head[0];

  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    err_d = err_d | {drop, bus.kbd_overflow};
  end

  always_ff @(posedge clk) begin
    if (clr) err_q <= 2'b00;
    else     err_q <= err_d;
  end

  assign err_flags = err_q;

endmodule
